// File: rtl/muldiv_hilo_unit_pkg.sv
// +--------------------------------------------------------------------+
// | muldiv_pkg : shared function codes and state/mode encodings         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package muldiv_pkg;

  localparam logic [3:0] FUNCT_MUL  = 4'b1010;
  localparam logic [3:0] FUNCT_DIV  = 4'b1111;
  localparam logic [3:0] FUNCT_MFHI = 4'b0101;
  localparam logic [3:0] FUNCT_MFLO = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_e;

endpackage

`default_nettype wire

// File: rtl/muldiv_hilo_unit_if.sv
// +--------------------------------------------------------------------+
// | muldiv_hilo_unit_if : operand/control bus between EX and MUL/DIV    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface muldiv_hilo_unit_if #(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 4
);
  logic               start;
  logic [FUNCT_W-1:0] FunctC;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               busy;
  logic               done;
  logic               DivByZero;
  logic [WIDTH-1:0]   Hi;
  logic [WIDTH-1:0]   Lo;
  logic [WIDTH-1:0]   HiLoOut;

  modport master (
    output start, FunctC, A, B,
    input  busy, done, DivByZero, Hi, Lo, HiLoOut
  );

  modport slave (
    input  start, FunctC, A, B,
    output busy, done, DivByZero, Hi, Lo, HiLoOut
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_hilo_unit_iter_step.sv
// +--------------------------------------------------------------------+
// | muldiv_iter_step : one combinational shift-add / restoring step     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module muldiv_iter_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mode_e              mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   rem,
  input  logic [WIDTH-1:0]   quo,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0]   rem_next,
  output logic [WIDTH-1:0]   quo_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : '0);
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, b};
    acc_next = acc;
    rem_next = rem;
    quo_next = quo;
    if (mode == MODE_MUL) begin
      // carry out of the add lands in the top bit after the right shift
      acc_next = {sum, acc[WIDTH-1:1]};
    end else if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_hilo_unit.sv
// +--------------------------------------------------------------------+
// | muldiv_hilo_unit : iterative unsigned mul/div owning HI/LO          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  muldiv_hilo_unit_if.slave  bus
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  logic               start_mul;
  logic               start_div;
  logic               b_zero;
  logic               last_iter;
  mode_e              step_mode;
  logic [2*WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0]   rem_nx;
  logic [WIDTH-1:0]   quo_nx;

  assign start_mul = bus.start && (bus.FunctC == FUNCT_W'(FUNCT_MUL));
  assign start_div = bus.start && (bus.FunctC == FUNCT_W'(FUNCT_DIV));
  assign b_zero    = (bus.B == '0);
  assign last_iter = (count_q == LAST);
  assign step_mode = (state_q == ST_DIV) ? MODE_DIV : MODE_MUL;

  muldiv_iter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .mode     (step_mode),
    .acc      (acc_q),
    .rem      (rem_q),
    .quo      (quo_q),
    .b        (b_q),
    .acc_next (acc_nx),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_mul) begin
          state_d = ST_MUL;
        end else if (start_div) begin
          state_d = b_zero ? ST_DONE : ST_DIV;
        end
      end
      ST_MUL, ST_DIV: begin
        if (last_iter) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: HI/LO only change at the end of a run or on divide-by-zero.
  always_comb begin
    count_d = count_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (start_mul) begin
          acc_d   = {{WIDTH{1'b0}}, bus.A};
          b_d     = bus.B;
          count_d = '0;
          dbz_d   = 1'b0;
        end else if (start_div) begin
          dbz_d = b_zero;
          if (b_zero) begin
            hi_d = bus.A;
            lo_d = '1;
          end else begin
            rem_d   = '0;
            quo_d   = bus.A;
            b_d     = bus.B;
            count_d = '0;
          end
        end
      end
      ST_MUL: begin
        acc_d   = acc_nx;
        count_d = count_q + 1'b1;
        if (last_iter) begin
          hi_d    = acc_nx[2*WIDTH-1:WIDTH];
          lo_d    = acc_nx[WIDTH-1:0];
          count_d = '0;
        end
      end
      ST_DIV: begin
        rem_d   = rem_nx;
        quo_d   = quo_nx;
        count_d = count_q + 1'b1;
        if (last_iter) begin
          hi_d    = rem_nx;
          lo_d    = quo_nx;
          count_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == ST_MUL) || (state_q == ST_DIV);
    bus.done = (state_q == ST_DONE);
  end

  always_comb begin
    bus.HiLoOut = '0;
    if (bus.FunctC == FUNCT_W'(FUNCT_MFHI)) begin
      bus.HiLoOut = hi_q;
    end else if (bus.FunctC == FUNCT_W'(FUNCT_MFLO)) begin
      bus.HiLoOut = lo_q;
    end
  end

  assign bus.Hi        = hi_q;
  assign bus.Lo        = lo_q;
  assign bus.DivByZero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_hilo_unit.sv
// +--------------------------------------------------------------------+
// | tb_muldiv_hilo_unit : directed vectors and multi-cycle corner cases |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_muldiv_hilo_unit;

  localparam logic [3:0] F_MUL  = 4'b1010;
  localparam logic [3:0] F_DIV  = 4'b1111;
  localparam logic [3:0] F_MFHI = 4'b0101;
  localparam logic [3:0] F_MFLO = 4'b0111;

  typedef struct {
    logic [3:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  muldiv_hilo_unit_if #(.WIDTH(32), .FUNCT_W(4)) bus ();

  muldiv_hilo_unit #(
    .WIDTH   (32),
    .FUNCT_W (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues a request at edge E and returns the cycle index (E+k) of done.
  task automatic run_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int nbusy);
    int l;
    int nb;
    @(negedge clk);
    bus.start = 1'b1; bus.FunctC = f; bus.A = a; bus.B = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.FunctC = F_MFLO;
    l = -1; nb = 0;
    for (int k = 1; k <= 100 && l < 0; k++) begin
      @(negedge clk);
      if (bus.busy) nb++;
      if (bus.done) l = k;
    end
    lat = l; nbusy = nb;
  endtask

  vec_t vecs [11];

  initial begin : main
    int lat;
    int nbusy;
    int done_seen;
    n_checks = 0;
    n_errors = 0;

    vecs[0]  = '{F_MUL, 32'd7,          32'd6,          32'd0,          32'd42,         1'b0, 33};
    vecs[1]  = '{F_MUL, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   32'h00000001,   1'b0, 33};
    vecs[2]  = '{F_DIV, 32'd100,        32'd7,          32'd2,          32'd14,         1'b0, 33};
    vecs[3]  = '{F_DIV, 32'd5,          32'd0,          32'd5,          32'hFFFFFFFF,   1'b1, 1};
    vecs[4]  = '{F_MUL, 32'd3,          32'd3,          32'd0,          32'd9,          1'b0, 33};
    vecs[5]  = '{F_DIV, 32'hFFFFFFFF,   32'd1,          32'd0,          32'hFFFFFFFF,   1'b0, 33};
    vecs[6]  = '{F_DIV, 32'd7,          32'd100,        32'd7,          32'd0,          1'b0, 33};
    vecs[7]  = '{F_MUL, 32'h00010000,   32'h00010000,   32'd1,          32'd0,          1'b0, 33};
    vecs[8]  = '{F_DIV, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd0,          32'd1,          1'b0, 33};
    vecs[9]  = '{F_MUL, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 33};
    vecs[10] = '{F_DIV, 32'd1000,       32'd33,         32'd10,         32'd30,         1'b0, 33};

    bus.start = 1'b0; bus.FunctC = 4'b0000; bus.A = '0; bus.B = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_dbz",  bus.DivByZero, 0);
    chk("reset_hi",   bus.Hi, 0);
    chk("reset_lo",   bus.Lo, 0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].funct, vecs[i].a, vecs[i].b, lat, nbusy);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_busy_cycles", i), nbusy, vecs[i].lat - 1);
      chk($sformatf("v%0d_hi", i), bus.Hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), bus.Lo, vecs[i].lo);
      chk($sformatf("v%0d_dbz", i), bus.DivByZero, vecs[i].dbz);
      chk($sformatf("v%0d_mflo", i), bus.HiLoOut, vecs[i].lo);
      bus.FunctC = F_MFHI; #1;
      chk($sformatf("v%0d_mfhi", i), bus.HiLoOut, vecs[i].hi);
      bus.FunctC = 4'b0000; #1;
      chk($sformatf("v%0d_hilo_other", i), bus.HiLoOut, 0);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), bus.done, 0);
    end

    // Old HI/LO visible during a run; a start mid-run is ignored.
    run_op(F_DIV, 32'd100, 32'd7, lat, nbusy);
    chk("seq_div_lo", bus.Lo, 14);
    @(negedge clk);
    bus.start = 1'b1; bus.FunctC = F_MUL; bus.A = 32'd3; bus.B = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.FunctC = F_MFLO;
    lat = -1; nbusy = 0;
    for (int k = 1; k <= 100 && lat < 0; k++) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
      if (bus.done) lat = k;
      if (bus.busy && k != 10) chk($sformatf("ign_mflo_k%0d", k), bus.HiLoOut, 14);
      if (k == 10) begin
        bus.start = 1'b1; bus.FunctC = F_DIV; bus.A = 32'd50; bus.B = 32'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.FunctC = F_MFLO;
      end
    end
    chk("ign_latency", lat, 33);
    chk("ign_busy_cycles", nbusy, 32);
    chk("ign_lo", bus.Lo, 9);
    chk("ign_hi", bus.Hi, 0);

    // A start presented during DONE is ignored.
    bus.start = 1'b1; bus.FunctC = F_DIV; bus.A = 32'd9; bus.B = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.FunctC = F_MFLO;
    @(negedge clk);
    chk("done_start_busy", bus.busy, 0);
    chk("done_start_done", bus.done, 0);
    chk("done_start_lo", bus.Lo, 9);

    // Unsupported code in IDLE is ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.FunctC = F_MFHI; bus.A = 32'd4; bus.B = 32'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.FunctC = F_MFLO;
    done_seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.busy || bus.done) done_seen++;
    end
    chk("badcode_no_activity", done_seen, 0);
    chk("badcode_lo", bus.Lo, 9);

    // Reset mid-run aborts and clears HI/LO.
    @(negedge clk);
    bus.start = 1'b1; bus.FunctC = F_MUL; bus.A = 32'd7; bus.B = 32'd6;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.FunctC = F_MFLO;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    chk("rst_pre_busy", bus.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_hi", bus.Hi, 0);
    chk("rst_lo", bus.Lo, 0);
    reset = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    chk("rst_no_done", done_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
